mdr_mem_unit: RTL and testbench
===============================

// Module: mdr_mem_unit
// PURPOSE
//   Memory Data Register plus memory read/write handshake for the 32-bit bus datapath.
//   Sits upstream of the bus multiplexer and drives its BusMuxIn_MDR input.
//   The MDR loads either from BusMuxOut (MDRin) or from memory (read transaction).
//   Its contents are the write data for memory write transactions, addressed by the MAR.
// PARAMETERS
//   DATA_W       32   datapath / MDR width
//   ADDR_W       9    memory word-address width (low ADDR_W bits of MAR)
//   TIMEOUT_CYC  16   request cycles without ack before abort (MDR_TIMEOUT_EN only)
// PORTS
//   clk            in   1       rising-edge clock
//   clr            in   1       asynchronous, active-low reset
//   BusMuxOut      in   DATA_W  bus value; MDR source when MDRin=1
//   MDRin          in   1       load MDR from BusMuxOut (honoured in IDLE only)
//   mar_q          in   DATA_W  current MAR contents (address source)
//   rd_start       in   1       start memory read into MDR (1-cycle pulse)
//   wr_start       in   1       start memory write of MDR (1-cycle pulse)
//   mem_rdata      in   DATA_W  memory read data, valid when mem_ack=1
//   mem_ack        in   1       memory completes current request
//   mem_req        out  1       request outstanding
//   mem_we         out  1       1=write, 0=read; valid while mem_req=1
//   mem_addr       out  ADDR_W  latched address
//   mem_wdata      out  DATA_W  latched write data
//   BusMuxIn_MDR   out  DATA_W  MDR contents, to bus multiplexer
//   mdr_busy       out  1       state != IDLE
//   mdr_done       out  1       1-cycle pulse, transaction completed
//   mem_err        out  1       1-cycle pulse on timeout (always 0 without MDR_TIMEOUT_EN)
// BEHAVIOUR
//   - Reset (clr=0, async): state IDLE; MDR, mem_addr, mem_wdata = 0; all 1-bit outputs = 0.
//     Reset mid-transaction aborts it: mem_req drops immediately and no mdr_done is issued.
//   - States: IDLE, RD_WAIT, WR_WAIT. All outputs are registered. BusMuxIn_MDR = MDR at all times.
//   - IDLE, MDRin=1: MDR <= BusMuxOut at the edge.
//   - IDLE, wr_start=1: mem_addr <= mar_q[ADDR_W-1:0] and mem_wdata <= MDR, both latched from
//     the pre-edge values. mem_req=1, mem_we=1. Go to WR_WAIT.
//   - IDLE, rd_start=1 (wr_start=0): latch mem_addr. mem_req=1, mem_we=0. Go to RD_WAIT.
//   - Simultaneous rd_start and wr_start: the write wins and the read is dropped.
//   - Simultaneous MDRin and rd_start: the bus load occurs, and the read later overwrites MDR.
//   - Simultaneous MDRin and wr_start: mem_wdata takes the old MDR, and MDR takes BusMuxOut.
//   - RD_WAIT/WR_WAIT: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
//   - Edge where mem_ack=1 is sampled:
//       - RD_WAIT: MDR <= mem_rdata.
//       - Either wait state: mem_req <= 0, mdr_done <= 1 for one cycle, go to IDLE.
//   - Minimum latency: start at edge N, ack sampled at edge N+1, mdr_done high in cycle N+1..N+2.
//   - Ignored inputs: rd_start, wr_start and MDRin while busy; mem_ack while in IDLE.
//   - A new start may be issued in the cycle mdr_done is high, since the block is back in IDLE.
// CONFIGURATION
//   MDR_TIMEOUT_EN defined:
//     - A counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle without ack.
//     - When it reaches TIMEOUT_CYC-1 without ack: mem_req <= 0, mem_err 1-cycle pulse, go to
//       IDLE. MDR is unchanged and no mdr_done is issued.
//     - An ack in the same cycle as the timeout wins (normal completion).
//   MDR_TIMEOUT_EN undefined: waits indefinitely; no counter logic; mem_err tied 0.
// STRUCTURE
//   - Shared package cpu_pkg holds: DATA_W/ADDR_W constants, the mdr_state_t enum
//     {IDLE, RD_WAIT, WR_WAIT}, and the TIMEOUT_CYC default.
//   - One sub-module: mdr_mem_fsm (state, handshake outputs, timeout counter).
//   - The MDR storage and source mux live in the top of this block.
// TESTING
//   1. Reset: clr=0 during RD_WAIT -> mem_req=0 immediately, BusMuxIn_MDR=0, mdr_busy=0.
//   2. Bus load: BusMuxOut=32'hDEADBEEF, MDRin=1 for 1 cycle -> BusMuxIn_MDR=32'hDEADBEEF
//      after that edge.
//   3. Read, ack after 3 cycles: mar_q=32'h5, mem_rdata=32'h12345678 ->
//      mem_addr=9'h005, mem_we=0, mem_req high 3 cycles, MDR=32'h12345678,
//      one mdr_done pulse.
//   4. Write: MDR=32'hA5A5A5A5, mar_q=32'h1FF, wr_start -> mem_we=1,
//      mem_addr=9'h1FF, mem_wdata=32'hA5A5A5A5 held until ack, then mdr_done.
//   5. Collisions:
//      - rd_start and wr_start together -> write only.
//      - rd_start while in WR_WAIT -> ignored.
//      - MDRin while busy -> MDR unchanged.
//   6. Timeout (MDR_TIMEOUT_EN, TIMEOUT_CYC=16): no ack -> mem_err pulse and mem_req=0
//      after 16 wait cycles, MDR unchanged. Macro off: mem_req still 1 after 100 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and the MDR transaction state type.
package cpu_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 9;
  localparam int TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_t;

endpackage

// File: rtl/mdr_mem_unit_fsm.sv
// Memory handshake sequencer for the MDR: state, registered request outputs and,
// when MDR_TIMEOUT_EN is defined, a wait-cycle counter that aborts stalled requests.
module mdr_mem_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] mdr_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              mdr_done,
  output logic              mem_err,
  output logic              rd_load
);

  mdr_state_t        state_q, state_nxt;
  logic              req_nxt, we_nxt, done_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             err_q, err_nxt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // MDR capture happens on the same edge that retires a read.
  assign rd_load = (state_q == RD_WAIT) && mem_ack;

  always_comb begin
    state_nxt = state_q;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    done_nxt  = 1'b0;
`ifdef MDR_TIMEOUT_EN
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Write has priority over a simultaneous read request.
        if (wr_start) begin
          addr_nxt  = addr_in;
          wdata_nxt = mdr_q;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = WR_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else if (rd_start) begin
          addr_nxt  = addr_in;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          state_nxt = RD_WAIT;
`ifdef MDR_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef MDR_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      mdr_done  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      busy      <= busy_nxt;
      mdr_done  <= done_nxt;
    end
  end

`ifdef MDR_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: rtl/mdr_mem_unit.sv
// Memory Data Register with bus/memory source mux and memory read/write handshake.
// Optional request timeout is enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int TIMEOUT_CYC = cpu_pkg::TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic [DATA_W-1:0] mar_q,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic              mdr_busy,
  output logic              mdr_done,
  output logic              mem_err
);

  logic [DATA_W-1:0] mdr_q;
  logic              busy;
  logic              rd_load;
  logic              unused_mar_hi;

  // Only the word-address bits of the MAR reach memory.
  assign unused_mar_hi = ^mar_q[DATA_W-1:ADDR_W];

  mdr_mem_fsm #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk       (clk),
    .clr       (clr),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mem_ack   (mem_ack),
    .addr_in   (mar_q[ADDR_W-1:0]),
    .mdr_q     (mdr_q),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .mdr_done  (mdr_done),
    .mem_err   (mem_err),
    .rd_load   (rd_load)
  );

  // Bus loads are only honoured in IDLE; read data lands only while busy.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mdr_q <= '0;
    end else if (!busy && MDRin) begin
      mdr_q <= BusMuxOut;
    end else if (rd_load) begin
      mdr_q <= mem_rdata;
    end
  end

  assign BusMuxIn_MDR = mdr_q;
  assign mdr_busy     = busy;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Self-checking bench for mdr_mem_unit: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_mdr_mem_unit;

  localparam int DW   = 32;
  localparam int AW   = 9;
  localparam int TCYC = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic [DW-1:0] BusMuxOut;
  logic          MDRin;
  logic [DW-1:0] mar_q;
  logic          rd_start;
  logic          wr_start;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] BusMuxIn_MDR;
  logic          mdr_busy;
  logic          mdr_done;
  logic          mem_err;

  mdr_mem_unit dut (
    .clk          (clk),
    .clr          (clr),
    .BusMuxOut    (BusMuxOut),
    .MDRin        (MDRin),
    .mar_q        (mar_q),
    .rd_start     (rd_start),
    .wr_start     (wr_start),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .mdr_busy     (mdr_busy),
    .mdr_done     (mdr_done),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an outstanding transaction and how long it has waited.
  logic [DW-1:0] m_mdr;
  logic          m_busy;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_waited;
  logic          exp_done;
  logic          exp_err;
  int            done_cnt;
  int            err_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mdr    = '0;
    m_busy   = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_waited = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_edge();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!clr) begin
      model_reset();
    end else if (!m_busy) begin
      if (wr_start || rd_start) begin
        m_busy   = 1'b1;
        m_write  = wr_start;
        m_addr   = mar_q[AW-1:0];
        m_waited = 0;
        if (wr_start) m_wdata = m_mdr;
      end
      if (MDRin) m_mdr = BusMuxOut;
    end else if (mem_ack) begin
      if (!m_write) m_mdr = mem_rdata;
      m_busy   = 1'b0;
      exp_done = 1'b1;
    end else begin
      m_waited++;
`ifdef MDR_TIMEOUT_EN
      if (m_waited == TCYC) begin
        m_busy  = 1'b0;
        exp_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic compare();
    chk("mem_req", mem_req, m_busy);
    chk("mdr_busy", mdr_busy, m_busy);
    chk("mdr_done", mdr_done, exp_done);
    chk("mem_err", mem_err, exp_err);
    chk("mdr", BusMuxIn_MDR, m_mdr);
    if (m_busy) begin
      chk("mem_we", mem_we, m_write);
      chk("mem_addr", mem_addr, m_addr);
      if (m_write) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mdr_done) done_cnt++;
    if (mem_err) err_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    MDRin    = 1'b0;
    rd_start = 1'b0;
    wr_start = 1'b0;
    mem_ack  = 1'b0;
  endtask

  initial begin
    int req_cycles;
    clr       = 1'b0;
    BusMuxOut = '0;
    mar_q     = '0;
    mem_rdata = '0;
    done_cnt  = 0;
    err_cnt   = 0;
    idle_inputs();
    model_reset();

    // Reset values
    #2;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_busy", mdr_busy, 1'b0);
    chk("rst_mdr", BusMuxIn_MDR, 32'h0);
    chk("rst_addr", mem_addr, 9'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_done", mdr_done, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    step();

    // Bus load
    BusMuxOut = 32'hDEADBEEF;
    MDRin     = 1'b1;
    step();
    MDRin = 1'b0;
    chk("bus_load", BusMuxIn_MDR, 32'hDEADBEEF);
    step();

    // Read, ack after 3 request cycles
    mar_q     = 32'h5;
    mem_rdata = 32'h12345678;
    rd_start  = 1'b1;
    req_cycles = 0;
    done_cnt   = 0;
    step();
    rd_start = 1'b0;
    if (mem_req) req_cycles++;
    chk("rd_addr", mem_addr, 9'h005);
    chk("rd_we", mem_we, 1'b0);
    step();
    if (mem_req) req_cycles++;
    step();
    if (mem_req) req_cycles++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    if (mem_req) req_cycles++;
    step();
    chk("rd_req_cycles", req_cycles, 3);
    chk("rd_mdr", BusMuxIn_MDR, 32'h12345678);
    chk("rd_done_pulses", done_cnt, 1);

    // Write with held outputs
    BusMuxOut = 32'hA5A5A5A5;
    MDRin     = 1'b1;
    step();
    MDRin    = 1'b0;
    mar_q    = 32'h1FF;
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    mar_q    = 32'h0;
    repeat (3) step();
    chk("wr_we", mem_we, 1'b1);
    chk("wr_addr", mem_addr, 9'h1FF);
    chk("wr_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_done", mdr_done, 1'b1);

    // Collisions: rd+wr, rd while WR_WAIT, MDRin while busy, MDRin+wr_start
    mar_q     = 32'h0000_0ABC;
    BusMuxOut = 32'h0BAD_F00D;
    rd_start  = 1'b1;
    wr_start  = 1'b1;
    MDRin     = 1'b1;
    step();
    wr_start  = 1'b0;
    BusMuxOut = 32'hFFFF_0000;
    step();
    chk("coll_we", mem_we, 1'b1);
    chk("coll_mdr", BusMuxIn_MDR, 32'h0BAD_F00D);
    chk("coll_wdata", mem_wdata, 32'hA5A5A5A5);
    rd_start = 1'b0;
    MDRin    = 1'b0;
    mem_ack  = 1'b1;
    step();
    // Back-to-back start in the done cycle, with MDRin+rd_start together
    mem_ack   = 1'b0;
    rd_start  = 1'b1;
    MDRin     = 1'b1;
    BusMuxOut = 32'h1111_2222;
    mem_rdata = 32'h3333_4444;
    step();
    rd_start = 1'b0;
    MDRin    = 1'b0;
    chk("b2b_bus", BusMuxIn_MDR, 32'h1111_2222);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("b2b_rd", BusMuxIn_MDR, 32'h3333_4444);
    step();

    // Stalled request
    rd_start = 1'b1;
    err_cnt  = 0;
    step();
    rd_start = 1'b0;
`ifdef MDR_TIMEOUT_EN
    repeat (TCYC + 2) step();
    chk("to_err_pulses", err_cnt, 1);
    chk("to_req", mem_req, 1'b0);
    chk("to_mdr", BusMuxIn_MDR, 32'h3333_4444);
`else
    repeat (100) step();
    chk("noto_req", mem_req, 1'b1);
    chk("noto_err_pulses", err_cnt, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
`endif

    // Random traffic
    repeat (400) begin
      MDRin     = ($urandom_range(0, 3) == 0);
      rd_start  = ($urandom_range(0, 3) == 0);
      wr_start  = ($urandom_range(0, 4) == 0);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mar_q     = $urandom;
      BusMuxOut = $urandom;
      mem_rdata = $urandom;
      step();
    end
    idle_inputs();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;

    // Reset during RD_WAIT
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    chk("pre_rst_req", mem_req, 1'b1);
    #3;
    clr = 1'b0;
    #1;
    model_reset();
    chk("arst_req", mem_req, 1'b0);
    chk("arst_mdr", BusMuxIn_MDR, 32'h0);
    chk("arst_busy", mdr_busy, 1'b0);
    step();
    @(negedge clk);
    clr      = 1'b1;
    mem_ack  = 1'b1;
    done_cnt = 0;
    repeat (3) step();
    mem_ack = 1'b0;
    chk("arst_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
